// File: rtl/fft_r22sdf_twiddle_gen_if.sv
// Twiddle generator port bundle: stage counter in,
// aligned counter, twiddle and phase out.
interface fft_r22sdf_twiddle_gen_if #(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10
);
    logic [NLOG2-1:0]                ctr_i;
    logic [NLOG2-1:0]                ctr_o;
    logic signed [TWIDDLE_WIDTH-1:0] w_re_o;
    logic signed [TWIDDLE_WIDTH-1:0] w_im_o;
    logic [1:0]                      phase_o;

    modport master (
        output ctr_i,
        input  ctr_o,
        input  w_re_o,
        input  w_im_o,
        input  phase_o
    );

    modport slave (
        input  ctr_i,
        output ctr_o,
        output w_re_o,
        output w_im_o,
        output phase_o
    );
endinterface

// File: rtl/fft_r22sdf_twiddle_gen.sv
// R2^2 SDF twiddle generator: counter -> k = f(t)*m,
// quarter-wave cosine ROM read twice per clk_i period, quadrant fold.
module fft_r22sdf_twiddle_gen #(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int FFT_N         = 1024,
    parameter int NLOG2         = 10
) (
    input logic                    clk_3x_i,
    input logic                    rst_n,
    fft_r22sdf_twiddle_gen_if.slave tw
);
    localparam int QN    = FFT_N / 4;
    localparam int UNITY = 2 ** (TWIDDLE_WIDTH - 1) - 1;
    localparam int RW    = NLOG2 - 2;
    localparam int AW    = NLOG2 - 1;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    typedef logic signed [TWIDDLE_WIDTH-1:0] tw_t;

    function automatic tw_t cos_entry(input int i);
        real x;
        if (i == QN) begin
            return '0;
        end
        x = $cos(2.0 * 3.14159265358979323846 * i / FFT_N) * UNITY;
        return TWIDDLE_WIDTH'($rtoi(x + 0.5));
    endfunction

    tw_t rom [QN+1];

    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        assign rom[gi] = cos_entry(gi);
    end

    phase_e           phase_q;
    phase_e           phase_d;
    logic [NLOG2-1:0] ctr_q;
    logic [NLOG2-1:0] ctr_o_q;
    logic [1:0]       q_q;
    tw_t              a_q;
    tw_t              b_q;
    tw_t              re_q;
    tw_t              im_q;

    logic [1:0]       t_w;
    logic [1:0]       f_w;
    logic [1:0]       q_w;
    logic [RW-1:0]    m_w;
    logic [RW-1:0]    r_w;
    logic [NLOG2-1:0] m_ext;
    logic [NLOG2-1:0] k_w;
    logic [AW-1:0]    r_ext;
    logic [AW-1:0]    addr_w;
    tw_t              rd_w;
    tw_t              re_w;
    tw_t              im_w;

    assign t_w   = ctr_q[NLOG2-1 -: 2];
    assign m_w   = ctr_q[RW-1:0];
    assign f_w   = {t_w[0], t_w[1]};
    assign m_ext = {2'b00, m_w};
    assign k_w   = (f_w[0] ? m_ext : '0)
                 + (f_w[1] ? {m_ext[NLOG2-2:0], 1'b0} : '0);
    assign q_w   = k_w[NLOG2-1 -: 2];
    assign r_w   = k_w[RW-1:0];
    assign r_ext = {1'b0, r_w};

    // Phase 0 reads cos(r), phase 1 reads cos(N/4 - r) i.e. sin(r)
    assign addr_w = (phase_q == PH0) ? r_ext : AW'(QN) - r_ext;
    assign rd_w   = rom[addr_w];

    // Phase sequencer register
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            phase_q <= PH0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state: 0 -> 1 -> 2 -> 0, stray 3 recovers to 0
    always_comb begin
        phase_d = PH0;
        case (phase_q)
            PH0:     phase_d = PH1;
            PH1:     phase_d = PH2;
            default: phase_d = PH0;
        endcase
    end

    // Quadrant fold of the two ROM reads into exp(-j*theta)
    always_comb begin
        re_w = '0;
        im_w = '0;
        unique case (1'b1)
            (q_q == 2'd0): begin re_w = a_q;  im_w = -b_q; end
            (q_q == 2'd1): begin re_w = -b_q; im_w = -a_q; end
            (q_q == 2'd2): begin re_w = -a_q; im_w = b_q;  end
            (q_q == 2'd3): begin re_w = b_q;  im_w = a_q;  end
        endcase
    end

    // Datapath: ROM captures in phases 0/1, sample and emit at end of phase 2
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            ctr_q   <= '0;
            ctr_o_q <= '0;
            q_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            if (phase_q == PH0) begin
                a_q <= rd_w;
                q_q <= q_w;
            end
            if (phase_q == PH1) begin
                b_q <= rd_w;
            end
            if (phase_q == PH2) begin
                ctr_q   <= tw.ctr_i;
                ctr_o_q <= ctr_q;
                re_q    <= re_w;
                im_q    <= im_w;
            end
        end
    end

    assign tw.ctr_o   = ctr_o_q;
    assign tw.w_re_o  = re_q;
    assign tw.w_im_o  = im_q;
    assign tw.phase_o = phase_q;
endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// Bench for fft_r22sdf_twiddle_gen: directed, sweep and random
// counters against an exp(-j*2*pi*k/N) model.
module tb_fft_r22sdf_twiddle_gen;
    localparam int TW = 10;
    localparam int N  = 1024;
    localparam int NL = 10;
    localparam real PI = 3.14159265358979323846;

    logic clk_3x_i = 1'b0;
    logic rst_n    = 1'b0;

    fft_r22sdf_twiddle_gen_if #(
        .TWIDDLE_WIDTH(TW),
        .NLOG2        (NL)
    ) tw ();

    fft_r22sdf_twiddle_gen #(
        .TWIDDLE_WIDTH(TW),
        .FFT_N        (N),
        .NLOG2        (NL)
    ) dut (
        .clk_3x_i(clk_3x_i),
        .rst_n   (rst_n),
        .tw      (tw.slave)
    );

    always #5 clk_3x_i = ~clk_3x_i;

    int errs   = 0;
    int checks = 0;
    int last   = 0;
    int exp_re = 0;
    int exp_im = 0;
    int exp_ct = 0;

    task automatic chk(input string tag, input integer got, input integer exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic void model(input int c, output int re, output int im);
        int t;
        int m;
        int f;
        real th;
        t = c / (N / 4);
        m = c % (N / 4);
        case (t)
            0:       f = 0;
            1:       f = 2;
            2:       f = 1;
            default: f = 3;
        endcase
        th = 2.0 * PI * real'(f * m) / real'(N);
        re = rnd(511.0 * $cos(th));
        im = -rnd(511.0 * $sin(th));
    endfunction

    task automatic step();
        @(posedge clk_3x_i);
        #1;
    endtask

    task automatic period(input int v);
        tw.ctr_i = NL'(v);
        for (int s = 1; s <= 3; s++) begin
            step();
            chk("phase", tw.phase_o, s % 3);
            if (s < 3) begin
                chk("hold_re", $signed(tw.w_re_o), exp_re);
                chk("hold_im", $signed(tw.w_im_o), exp_im);
                chk("hold_ctr", tw.ctr_o, exp_ct);
            end
        end
        model(last, exp_re, exp_im);
        exp_ct = last;
        chk("w_re", $signed(tw.w_re_o), exp_re);
        chk("w_im", $signed(tw.w_im_o), exp_im);
        chk("ctr_o", tw.ctr_o, exp_ct);
        last = v;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_re"}, $signed(tw.w_re_o), 0);
        chk({tag, "_im"}, $signed(tw.w_im_o), 0);
        chk({tag, "_ctr"}, tw.ctr_o, 0);
        chk({tag, "_ph"}, tw.phase_o, 0);
    endtask

    task automatic release_reset();
        rst_n  = 1'b1;
        last   = 0;
        exp_re = 0;
        exp_im = 0;
        exp_ct = 0;
    endtask

    initial begin
        tw.ctr_i = '0;
        rst_n    = 1'b0;
        step();
        step();
        step();
        chk_reset_state("rst");
        release_reset();

        period(0);
        period(320);
        chk("k0_re", $signed(tw.w_re_o), 511);
        chk("k0_im", $signed(tw.w_im_o), 0);
        period(384);
        chk("k128_re", $signed(tw.w_re_o), 361);
        chk("k128_im", $signed(tw.w_im_o), -361);
        period(1023);
        chk("k256_re", $signed(tw.w_re_o), 0);
        chk("k256_im", $signed(tw.w_im_o), -511);
        period(0);
        chk("k765_re", $signed(tw.w_re_o), -9);
        chk("k765_im", $signed(tw.w_im_o), 511);
        chk("k765_ctr", tw.ctr_o, 1023);

        for (int v = 0; v < N; v++) begin
            period(v);
        end
        period(0);

        for (int i = 0; i < 3; i++) begin
            period(77);
        end

        for (int i = 0; i < 150; i++) begin
            period(int'($urandom_range(0, N - 1)));
        end

        tw.ctr_i = NL'(600);
        step();
        rst_n = 1'b0;
        step();
        chk_reset_state("mid_rst1");
        step();
        chk_reset_state("mid_rst2");
        release_reset();

        period(831);
        period(int'($urandom_range(0, N - 1)));
        for (int i = 0; i < 60; i++) begin
            period(int'($urandom_range(0, N - 1)));
        end
        period(0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
